// File: rtl/op_pkg.sv
// Shared types for the operand issue queue.
// One bundle carries the mux select, ALU select and both operands.
package op_pkg;
  localparam int W = 8;
  localparam int OP_W = 2 + 2 * W;

  typedef struct packed {
    logic         x;
    logic         sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;
endpackage

// File: rtl/op_issue_queue_if.sv
// Producer-side and issue-side handshakes of the operand issue queue.
// The master drives bundles and consumes results; the slave is the queue.
interface op_issue_queue_if
  import op_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          in_x;
  logic          in_sel;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          iss_valid;
  logic          iss_ready;
  logic          x;
  logic          sel;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [CW-1:0] count;
  logic          drop;

  modport master (
    output flush, in_valid, in_x, in_sel, in_a, in_b, iss_ready,
    input  in_ready, iss_valid, x, sel, a, b, count, drop
  );

  modport slave (
    input  flush, in_valid, in_x, in_sel, in_a, in_b, iss_ready,
    output in_ready, iss_valid, x, sel, a, b, count, drop
  );
endinterface

// File: rtl/op_fifo.sv
// Circular bundle buffer with occupancy count and flush.
// Storage is not reset; only pointers and count are.
module op_fifo
  import op_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  op_t           wdata,
  input  logic          pop,
  output op_t           rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  op_t           mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push)
      mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/op_issue_queue.sv
// Operand staging FIFO plus a stable issue register feeding the mux-ALU.
// No bypass: every bundle spends at least one cycle in the FIFO.
module op_issue_queue
  import op_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  op_issue_queue_if.slave  bus
);
  op_t  head;
  op_t  in_op;
  op_t  iss_q;
  logic full;
  logic empty;
  logic load;
  logic iss_valid_q;
  logic drop_q;

  assign in_op = '{x: bus.in_x, sel: bus.in_sel, a: bus.in_a, b: bus.in_b};
  assign load  = !empty && (!iss_valid_q || bus.iss_ready);

  op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.flush),
    .push  (bus.in_valid),
    .wdata (in_op),
    .pop   (load),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (bus.count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
      drop_q      <= 1'b0;
    end else begin
      // drop survives flush; only reset clears it
      if (bus.in_valid && full) drop_q <= 1'b1;
      if (bus.flush) begin
        iss_valid_q <= 1'b0;
      end else if (load) begin
        iss_q       <= head;
        iss_valid_q <= 1'b1;
      end else if (bus.iss_ready) begin
        iss_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = !full;
  assign bus.iss_valid = iss_valid_q;
  assign bus.x         = iss_q.x;
  assign bus.sel       = iss_q.sel;
  assign bus.a         = iss_q.a;
  assign bus.b         = iss_q.b;
  assign bus.drop      = drop_q;
endmodule

// File: tb/tb_op_issue_queue.sv
// Bench for op_issue_queue: table vectors, directed corners, random traffic.
// A queue-based reference model is checked after every clock edge.
module tb_op_issue_queue;
  import op_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  op_issue_queue_if #(.DEPTH(DEPTH)) bus ();

  op_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  op_t q[$];
  bit  mv;
  op_t mi;
  bit  mdrop;

  typedef struct {
    bit         r;
    bit         v;
    bit         x;
    logic [7:0] a;
    logic [7:0] b;
    bit         rdy;
    bit         e_iv;
    int         e_cnt;
    bit         e_ir;
    bit         e_drop;
    logic [7:0] e_a;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit f,
                                     input bit v, input op_t d,
                                     input bit rdy);
    bit  full;
    bit  pop;
    op_t h;
    if (!r) begin
      q.delete();
      mv = 0;
      mi = '0;
      mdrop = 0;
      return;
    end
    full = (q.size() == DEPTH);
    if (v && full) mdrop = 1;
    if (f) begin
      q.delete();
      mv = 0;
      return;
    end
    pop = (q.size() > 0) && (!mv || rdy);
    h = '0;
    if (pop) h = q.pop_front();
    if (v && !full) q.push_back(d);
    if (pop) begin
      mi = h;
      mv = 1;
    end else if (rdy) begin
      mv = 0;
    end
  endfunction

  task automatic cmp_model();
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    chk("iss_valid", 32'(bus.iss_valid), 32'(mv));
    chk("x", 32'(bus.x), 32'(mi.x));
    chk("sel", 32'(bus.sel), 32'(mi.sel));
    chk("a", 32'(bus.a), 32'(mi.a));
    chk("b", 32'(bus.b), 32'(mi.b));
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("drop", 32'(bus.drop), 32'(mdrop));
  endtask

  task automatic step(input bit r, input bit f, input bit v,
                      input op_t d, input bit rdy);
    rst_n         = r;
    bus.flush     = f;
    bus.in_valid  = v;
    bus.in_x      = d.x;
    bus.in_sel    = d.sel;
    bus.in_a      = d.a;
    bus.in_b      = d.b;
    bus.iss_ready = rdy;
    model_step(r, f, v, d, rdy);
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  function automatic op_t mk(input bit x, input bit s,
                             input logic [7:0] a, input logic [7:0] b);
    op_t o;
    o.x = x;
    o.sel = s;
    o.a = a;
    o.b = b;
    return o;
  endfunction

  initial begin
    op_t z;
    op_t d;
    logic [CW-1:0] c0;
    z = '0;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_x = 1'b0;
    bus.in_sel = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.iss_ready = 1'b0;
    step(0, 0, 0, z, 0);

    vt[0]  = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00};
    vt[1]  = '{1, 1, 1, 8'h3C, 8'h0F, 0, 0, 1, 1, 0, 8'h00};
    vt[2]  = '{1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 1, 0, 8'h3C};
    vt[3]  = '{1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 1, 0, 8'h3C};
    vt[4]  = '{1, 1, 0, 8'h01, 8'hFE, 0, 1, 1, 1, 0, 8'h3C};
    vt[5]  = '{1, 1, 0, 8'h02, 8'hFD, 0, 1, 2, 1, 0, 8'h3C};
    vt[6]  = '{1, 1, 0, 8'h03, 8'hFC, 0, 1, 3, 1, 0, 8'h3C};
    vt[7]  = '{1, 1, 0, 8'h04, 8'hFB, 0, 1, 4, 0, 0, 8'h3C};
    vt[8]  = '{1, 1, 0, 8'h05, 8'hFA, 0, 1, 4, 0, 1, 8'h3C};
    vt[9]  = '{1, 0, 0, 8'h00, 8'h00, 1, 1, 3, 1, 1, 8'h01};
    vt[10] = '{1, 0, 0, 8'h00, 8'h00, 1, 1, 2, 1, 1, 8'h02};
    vt[11] = '{1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 1, 8'h03};
    vt[12] = '{1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 1, 8'h04};
    vt[13] = '{1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 1, 8'h04};

    foreach (vt[i]) begin
      step(vt[i].r, 0, vt[i].v, mk(vt[i].x, 0, vt[i].a, vt[i].b),
           vt[i].rdy);
      chk($sformatf("vec%0d.iv", i), 32'(bus.iss_valid), 32'(vt[i].e_iv));
      chk($sformatf("vec%0d.cnt", i), 32'(bus.count), 32'(vt[i].e_cnt));
      chk($sformatf("vec%0d.ir", i), 32'(bus.in_ready), 32'(vt[i].e_ir));
      chk($sformatf("vec%0d.drop", i), 32'(bus.drop), 32'(vt[i].e_drop));
      chk($sformatf("vec%0d.a", i), 32'(bus.a), 32'(vt[i].e_a));
    end

    // streaming: one bundle per cycle, no gaps
    step(0, 0, 0, z, 0);
    for (int c = 0; c < 18; c++) begin
      step(1, 0, c < 16, mk(c[0], c[1], 8'(8'h10 + c), 8'(c)), 1);
      if (c >= 1 && c <= 16) begin
        chk("stream.iv", 32'(bus.iss_valid), 32'd1);
        chk("stream.a", 32'(bus.a), 32'(8'h10 + c - 1));
      end
      chk("stream.cnt_le1", 32'(bus.count <= 1), 32'd1);
    end

    // simultaneous push and pop at count 2, across the wrap
    step(0, 0, 0, z, 0);
    step(1, 0, 1, mk(0, 0, 8'hA0, 8'h00), 0);
    step(1, 0, 1, mk(0, 1, 8'hA1, 8'h01), 0);
    step(1, 0, 1, mk(1, 0, 8'hA2, 8'h02), 0);
    chk("pp.pre_cnt", 32'(bus.count), 32'd2);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 1, mk(k[0], 1, 8'(8'hB0 + k), 8'(k)), 1);
      chk("pp.cnt", 32'(bus.count), 32'd2);
      chk("pp.a", 32'(bus.a), k == 0 ? 32'hA1 : k == 1 ? 32'hA2
                                               : 32'(8'hB0 + k - 2));
    end
    for (int k = 0; k < 4; k++) step(1, 0, 0, z, 1);

    // flush with count=3, iss_valid=1 and a push in the same cycle
    step(0, 0, 0, z, 0);
    for (int k = 0; k < 6; k++)
      step(1, 0, 1, mk(1, 1, 8'(8'hC0 + k), 8'hEE), 0);
    chk("fl.drop_set", 32'(bus.drop), 32'd1);
    step(1, 0, 0, z, 1);
    chk("fl.pre_cnt", 32'(bus.count), 32'd3);
    chk("fl.pre_iv", 32'(bus.iss_valid), 32'd1);
    step(1, 1, 1, mk(0, 0, 8'hDD, 8'hDD), 0);
    chk("fl.cnt", 32'(bus.count), 32'd0);
    chk("fl.iv", 32'(bus.iss_valid), 32'd0);
    chk("fl.drop", 32'(bus.drop), 32'd1);
    step(1, 0, 0, z, 0);
    step(1, 0, 0, z, 0);
    chk("fl.absent_iv", 32'(bus.iss_valid), 32'd0);
    chk("fl.absent_cnt", 32'(bus.count), 32'd0);

    // reset mid-stream, then 2-cycle latency
    for (int k = 0; k < 5; k++)
      step(1, 0, 1, mk(1, 0, 8'(8'h50 + k), 8'h11), k[0]);
    step(0, 0, 1, mk(1, 1, 8'h77, 8'h77), 1);
    chk("rst.iv", 32'(bus.iss_valid), 32'd0);
    chk("rst.cnt", 32'(bus.count), 32'd0);
    chk("rst.drop", 32'(bus.drop), 32'd0);
    chk("rst.ir", 32'(bus.in_ready), 32'd1);
    chk("rst.a", 32'(bus.a), 32'd0);
    step(1, 0, 1, mk(0, 1, 8'h9A, 8'h5B), 0);
    chk("lat.edge1_iv", 32'(bus.iss_valid), 32'd0);
    step(1, 0, 0, z, 0);
    chk("lat.edge2_iv", 32'(bus.iss_valid), 32'd1);
    chk("lat.a", 32'(bus.a), 32'h9A);
    chk("lat.b", 32'(bus.b), 32'h5B);
    chk("lat.sel", 32'(bus.sel), 32'd1);

    // random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      d = op_t'(OP_W'($urandom));
      c0 = bus.count;
      step($urandom_range(0, 199) != 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
      chk("rnd.cnt_range", 32'(bus.count <= CW'(DEPTH)), 32'd1);
      if (c0 == '0) chk("rnd.cnt_step", 32'(bus.count <= 1), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
